axi4s_vid_out_lite: RTL and testbench
=====================================

AXI4S_VID_OUT_LITE -- requirements
Module: axi4s_vid_out_lite

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: pixel width in bits for s_axis_video_tdata and vid_data.
REQ-002 SHALL have parameter FIFO_ADDR_BITS, default 5: pixel FIFO holds 2^FIFO_ADDR_BITS entries.
REQ-003 SHALL have ports aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have ports aresetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports aclken, input, 1: clock enable; when low, all state and outputs hold.
REQ-006 SHALL have ports enable, input, 1: run control; when low, the block is held idle.
REQ-007 SHALL have ports s_axis_video_tdata/tvalid/tready/tuser/tlast, in/in/out/in/in, DATA_WIDTH/1/1/1/1: AXI4-Stream video input (tuser = SOF, tlast = EOL).
REQ-008 SHALL have ports vtg_active_video, vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank, input, 1 each: timing from the external timing generator.
REQ-009 SHALL have ports vid_de, vid_hsync, vid_vsync, vid_hblank, vid_vblank, output, 1 each: registered video timing out.
REQ-010 SHALL have ports vid_data, output, DATA_WIDTH: registered pixel out.
REQ-011 SHALL have ports locked, output, 1: stream is frame-aligned to timing.
REQ-012 SHALL have ports underflow, output, 1: one-cycle pulse when a pixel is needed while the FIFO is empty.

Function
REQ-013 SHALL store {tuser, tlast, tdata} in a synchronous FIFO; tready = enable & !full; push on tvalid & tready & aclken.
REQ-014 SHALL define frame start (FS) as the cycle where vtg_vblank = 0 and its registered previous value = 1.
REQ-015 SHALL implement FSM IDLE -> FLUSH -> WAIT_FS -> LOCKED; locked = 1 only in LOCKED.
REQ-016 IDLE: entered when enable = 0; FIFO pointers cleared; leave to FLUSH when enable = 1.
REQ-017 FLUSH: pop and discard head entries while head tuser = 0; go to WAIT_FS when head is valid with tuser = 1 (head retained).
REQ-018 WAIT_FS: hold FIFO; on FS go to LOCKED; pixel consumption starts at the first vtg_active_video = 1 cycle.
REQ-019 LOCKED: pop one entry per vtg_active_video = 1 cycle; no pops otherwise.
REQ-020 LOCKED, active cycle with FIFO empty: vid_data = 0, underflow pulses, and the FSM goes to FLUSH.
REQ-021 LOCKED: popped tuser = 1 on a non-first active pixel of the frame, or tuser = 0 on the first active pixel, SHALL drop to FLUSH (entry kept as head if tuser = 1).
REQ-022 vid_* timing outputs SHALL equal the vtg_* inputs delayed exactly 1 aclken cycle; vid_data aligns with vid_de.
REQ-023 vid_data = popped pixel when vid_de = 1 and locked, else 0; vid_de follows vtg_active_video regardless of lock.
REQ-024 Simultaneous push and pop SHALL keep the level unchanged; a pop on empty never bypasses an in-flight push (reported as underflow).
REQ-025 tlast SHALL be carried through the FIFO but does not affect alignment.

Reset
REQ-026 While aresetn = 0 on a clock edge: FSM = IDLE, FIFO empty, tready = 0, every vid_* output = 0, vid_data = 0, locked = 0, underflow = 0.
REQ-027 Reset mid-frame SHALL discard all buffered pixels; after release, relock requires a fresh tuser and FS.
REQ-028 Reset SHALL take priority over aclken.

Configuration
REQ-029 Macro VID_OUT_UNDERFLOW_CNT_EN, when defined, SHALL add output underflow_cnt[15:0], which counts underflow pulses, saturates at 0xFFFF, and is cleared by reset or enable = 0.
REQ-030 Without VID_OUT_UNDERFLOW_CNT_EN, the port and counter SHALL be absent and all other behaviour is identical.

Verification
REQ-031 4x2 frame, stream pre-filled (first tuser = 1), FS then 8 active cycles: vid_data = pixels 0..7 in order, locked = 1 from FS + 1, underflow never asserts.
REQ-032 3 junk pixels (tuser = 0) before SOF: all 3 are discarded in FLUSH, and output frame 1 starts with the SOF pixel.
REQ-033 Stream stalls after 5 of 8 pixels: the 6th active cycle gives vid_data = 0, underflow = 1 for one cycle, locked = 0, and the block relocks on the next SOF plus FS.
REQ-034 FIFO filled to 32 with vtg idle: tready = 0 at full; with tvalid held, no data is lost.
REQ-035 aresetn pulsed low for 1 cycle mid-frame: the next cycle shows all outputs = 0, an empty FIFO, and the FSM in IDLE.
REQ-036 aclken = 0 for 3 cycles in LOCKED: outputs are frozen and the FIFO level is unchanged; with VID_OUT_UNDERFLOW_CNT_EN defined, 3 forced underflows give underflow_cnt = 3.

Source files
------------

// File: rtl/axi4s_vid_out_lite.sv
// AXI4-Stream video to native video output: pixel FIFO plus SOF/frame-start alignment FSM.
// Optional saturating underflow counter port when VID_OUT_UNDERFLOW_CNT_EN is defined.
module axi4s_vid_out_lite #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_ADDR_BITS = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  input  logic                  vtg_active_video,
  input  logic                  vtg_hsync,
  input  logic                  vtg_vsync,
  input  logic                  vtg_hblank,
  input  logic                  vtg_vblank,
  output logic                  vid_de,
  output logic                  vid_hsync,
  output logic                  vid_vsync,
  output logic                  vid_hblank,
  output logic                  vid_vblank,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  locked,
  output logic                  underflow
`ifdef VID_OUT_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]           underflow_cnt
`endif
);

  localparam int unsigned EW    = DATA_WIDTH + 2;
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_WAIT_FS = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  logic [EW-1:0]           mem_q [DEPTH];
  logic [FIFO_ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]              state_q, state_d;
  logic                    first_q, first_d;
  logic                    vblank_prev_q, vblank_prev_d;
  logic [4:0]              tim_q, tim_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    underflow_q, underflow_d;

  logic                      empty, full, push, pop, fs;
  logic                      head_sof;
  logic [DATA_WIDTH-1:0]     head_pix;
  logic [FIFO_ADDR_BITS-1:0] rd_idx, wr_idx;

  assign rd_idx   = rd_ptr_q[FIFO_ADDR_BITS-1:0];
  assign wr_idx   = wr_ptr_q[FIFO_ADDR_BITS-1:0];
  assign head_sof = mem_q[rd_idx][EW-1];
  assign head_pix = mem_q[rd_idx][DATA_WIDTH-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_ADDR_BITS] != rd_ptr_q[FIFO_ADDR_BITS]) &&
                 (wr_idx == rd_idx);

  assign s_axis_video_tready = aresetn & enable & ~full;
  assign push = s_axis_video_tvalid & s_axis_video_tready & aclken;
  assign fs   = vblank_prev_q & ~vtg_vblank;

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    pop           = 1'b0;
    data_d        = '0;
    underflow_d   = 1'b0;
    vblank_prev_d = vtg_vblank;
    tim_d         = {vtg_active_video, vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank};

    case (state_q)
      ST_IDLE: state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!empty) begin
          if (head_sof) state_d = ST_WAIT_FS;
          else          pop     = 1'b1;
        end
      end
      ST_WAIT_FS: begin
        if (fs) begin
          state_d = ST_LOCKED;
          first_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (fs) begin
          first_d = 1'b1;
        end else if (vtg_active_video) begin
          if (empty) begin
            underflow_d = 1'b1;
            state_d     = ST_FLUSH;
          end else if (first_q != head_sof) begin
            // Misplaced SOF stays at the head so FLUSH relocks on it; a missing SOF is dropped.
            state_d = ST_FLUSH;
            pop     = ~head_sof;
          end else begin
            pop     = 1'b1;
            data_d  = head_pix;
            first_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d     = ST_IDLE;
      pop         = 1'b0;
      data_d      = '0;
      underflow_d = 1'b0;
    end

    wr_ptr_d = enable ? wr_ptr_q + {{FIFO_ADDR_BITS{1'b0}}, push} : '0;
    rd_ptr_d = enable ? rd_ptr_q + {{FIFO_ADDR_BITS{1'b0}}, pop}  : '0;
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_idx] <= {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      first_q       <= 1'b0;
      vblank_prev_q <= 1'b0;
      tim_q         <= '0;
      data_q        <= '0;
      underflow_q   <= 1'b0;
    end else if (aclken) begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      first_q       <= first_d;
      vblank_prev_q <= vblank_prev_d;
      tim_q         <= tim_d;
      data_q        <= data_d;
      underflow_q   <= underflow_d;
    end
  end

  assign {vid_de, vid_hsync, vid_vsync, vid_hblank, vid_vblank} = tim_q;
  assign vid_data  = data_q;
  assign locked    = (state_q == ST_LOCKED);
  assign underflow = underflow_q;

`ifdef VID_OUT_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (!enable)                          ucnt_d = '0;
    else if (underflow_d && ucnt_q != '1) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)    ucnt_q <= '0;
    else if (aclken) ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_axi4s_vid_out_lite.sv
// Randomized bench for axi4s_vid_out_lite against a queue-based reference model.
module tb_axi4s_vid_out_lite;

  localparam int DW    = 16;
  localparam int AB    = 5;
  localparam int DEPTH = 1 << AB;
  localparam int HB    = 3;
  localparam int W     = 4;
  localparam int VB    = 2;
  localparam int H     = 2;

  logic          aclk;
  logic          aresetn, aclken, enable;
  logic [DW-1:0] s_axis_video_tdata;
  logic          s_axis_video_tvalid, s_axis_video_tready;
  logic          s_axis_video_tuser, s_axis_video_tlast;
  logic          vtg_active_video, vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank;
  logic          vid_de, vid_hsync, vid_vsync, vid_hblank, vid_vblank;
  logic [DW-1:0] vid_data;
  logic          locked, underflow;
`ifdef VID_OUT_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  axi4s_vid_out_lite #(.DATA_WIDTH(DW), .FIFO_ADDR_BITS(AB)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .aclken              (aclken),
    .enable              (enable),
    .s_axis_video_tdata  (s_axis_video_tdata),
    .s_axis_video_tvalid (s_axis_video_tvalid),
    .s_axis_video_tready (s_axis_video_tready),
    .s_axis_video_tuser  (s_axis_video_tuser),
    .s_axis_video_tlast  (s_axis_video_tlast),
    .vtg_active_video    (vtg_active_video),
    .vtg_hsync           (vtg_hsync),
    .vtg_vsync           (vtg_vsync),
    .vtg_hblank          (vtg_hblank),
    .vtg_vblank          (vtg_vblank),
    .vid_de              (vid_de),
    .vid_hsync           (vid_hsync),
    .vid_vsync           (vid_vsync),
    .vid_hblank          (vid_hblank),
    .vid_vblank          (vid_vblank),
    .vid_data            (vid_data),
    .locked              (locked),
    .underflow           (underflow)
`ifdef VID_OUT_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt       (underflow_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed { logic sof; logic [DW-1:0] pix; } ent_t;
  typedef enum int { M_IDLE, M_FLUSH, M_WAIT, M_LOCK } mode_t;

  ent_t  src[$];
  ent_t  mq[$];
  mode_t m_mode;
  logic  m_first, m_prev_vb, m_uf, m_tready;
  logic [4:0]    m_tim;
  logic [DW-1:0] m_data;
  logic [15:0]   m_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int uf_seen, lock_seen;

  bit ctl_rstn, ctl_en, ctl_vtg_run, ctl_gen;
  int unsigned ctl_clken_pct, ctl_valid_pct, ctl_junk_pct, ctl_drop_pct;
  int unsigned tx, ty;
  bit tv_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int unsigned junk, input int unsigned npix);
    ent_t e;
    for (int unsigned i = 0; i < junk; i++) begin
      e.sof = 1'b0; e.pix = DW'($urandom); src.push_back(e);
    end
    for (int unsigned i = 0; i < npix; i++) begin
      e.sof = (i == 0); e.pix = DW'($urandom); src.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; mq.delete(); m_first = 1'b0; m_prev_vb = 1'b0;
    m_uf = 1'b0; m_tim = '0; m_data = '0; m_cnt = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently driven.
  task automatic model_update();
    ent_t e;
    logic fs, do_push;
    if (!aresetn) begin
      model_reset();
    end else if (aclken) begin
      fs      = m_prev_vb && !vtg_vblank;
      do_push = s_axis_video_tvalid && m_tready;
      m_tim   = {vtg_active_video, vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank};
      m_data  = '0;
      m_uf    = 1'b0;
      if (!enable) begin
        m_mode = M_IDLE; mq.delete(); m_cnt = '0;
      end else begin
        case (m_mode)
          M_IDLE:  m_mode = M_FLUSH;
          M_FLUSH: if (mq.size() > 0) begin
                     if (mq[0].sof) m_mode = M_WAIT;
                     else void'(mq.pop_front());
                   end
          M_WAIT:  if (fs) begin m_mode = M_LOCK; m_first = 1'b1; end
          M_LOCK: begin
            if (fs) m_first = 1'b1;
            else if (vtg_active_video) begin
              if (mq.size() == 0) begin
                m_uf = 1'b1; m_mode = M_FLUSH;
              end else if (m_first && !mq[0].sof) begin
                void'(mq.pop_front()); m_mode = M_FLUSH;
              end else if (!m_first && mq[0].sof) begin
                m_mode = M_FLUSH;
              end else begin
                e = mq.pop_front(); m_data = e.pix; m_first = 1'b0;
              end
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      if (do_push) begin
        e.sof = s_axis_video_tuser; e.pix = s_axis_video_tdata; mq.push_back(e);
      end
      if (m_uf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_prev_vb = vtg_vblank;
    end
  endtask

  task automatic step();
    bit accepted;
    @(negedge aclk);
    chk("vid_timing", {vid_de, vid_hsync, vid_vsync, vid_hblank, vid_vblank}, m_tim);
    chk("vid_data", vid_data, m_data);
    chk("locked", locked, m_mode == M_LOCK);
    chk("underflow", underflow, m_uf);
`ifdef VID_OUT_UNDERFLOW_CNT_EN
    chk("underflow_cnt", underflow_cnt, m_cnt);
`endif
    if (underflow === 1'b1) uf_seen++;
    if (locked === 1'b1) lock_seen++;

    if (ctl_gen && src.size() < 4)
      push_frame(($urandom_range(99) < ctl_junk_pct) ? $urandom_range(1, 3) : 0,
                 ($urandom_range(99) < ctl_drop_pct) ? $urandom_range(1, 7) : W * H);

    aresetn = ctl_rstn;
    enable  = ctl_en;
    aclken  = ($urandom_range(99) < ctl_clken_pct);
    if (ctl_vtg_run) begin
      vtg_vblank       = (ty < VB);
      vtg_hblank       = (tx < HB);
      vtg_active_video = (ty >= VB) && (tx >= HB);
      vtg_hsync        = (tx == 0);
      vtg_vsync        = (ty == 0);
    end else begin
      vtg_vblank = 1'b1; vtg_hblank = 1'b1;
      vtg_active_video = 1'b0; vtg_hsync = 1'b0; vtg_vsync = 1'b0;
    end
    if (!tv_hold) s_axis_video_tvalid = (src.size() > 0) && ($urandom_range(99) < ctl_valid_pct);
    if (src.size() > 0) begin
      s_axis_video_tuser = src[0].sof; s_axis_video_tdata = src[0].pix;
    end else begin
      s_axis_video_tuser = 1'b0; s_axis_video_tdata = '0;
    end
    s_axis_video_tlast = 1'($urandom_range(1));
    #1;
    m_tready = aresetn && enable && (mq.size() < DEPTH);
    chk("tready", s_axis_video_tready, m_tready);
    model_update();

    accepted = s_axis_video_tvalid && m_tready && aclken;
    if (accepted) void'(src.pop_front());
    tv_hold = s_axis_video_tvalid && !accepted;
    if (aclken) begin
      if (ctl_vtg_run) begin
        tx++;
        if (tx == HB + W) begin
          tx = 0; ty++;
          if (ty == VB + H) ty = 0;
        end
      end else begin
        tx = 0; ty = 0;
      end
    end
  endtask

  task automatic restart(input int unsigned n);
    ctl_rstn = 1'b0;
    repeat (n) step();
    src.delete(); tv_hold = 1'b0; s_axis_video_tvalid = 1'b0;
    ctl_rstn = 1'b1;
  endtask

  task automatic wait_locked_de(input string tag);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      found = (locked === 1'b1) && (vid_de === 1'b1);
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] sof_val;
    int unsigned en_off;
    aresetn = 1'b0; enable = 1'b0; aclken = 1'b1;
    s_axis_video_tvalid = 1'b0; s_axis_video_tuser = 1'b0; s_axis_video_tlast = 1'b0;
    s_axis_video_tdata = '0;
    vtg_active_video = 1'b0; vtg_hsync = 1'b0; vtg_vsync = 1'b0;
    vtg_hblank = 1'b0; vtg_vblank = 1'b0;
    model_reset(); tx = 0; ty = 0; tv_hold = 1'b0;
    ctl_rstn = 1'b0; ctl_en = 1'b1; ctl_vtg_run = 1'b1; ctl_gen = 1'b0;
    ctl_clken_pct = 100; ctl_valid_pct = 100; ctl_junk_pct = 0; ctl_drop_pct = 0;
    uf_seen = 0; lock_seen = 0;

    // Reset state, then a clean pre-filled aligned stream
    repeat (4) step();
    ctl_rstn = 1'b1; ctl_gen = 1'b1; uf_seen = 0; lock_seen = 0;
    repeat (200) step();
    chk("aligned_no_underflow", uf_seen, 0);
    chk("aligned_locked", lock_seen != 0, 1'b1);

    // Junk pixels ahead of SOF are flushed; first output pixel is the SOF pixel
    restart(2);
    push_frame(3, W * H);
    sof_val = src[3].pix;
    wait_locked_de("junk_lock_found");
    chk("junk_sof_first", vid_data, sof_val);
    repeat (60) step();

    // Stream stalls after 5 pixels: one underflow, unlock, then relock
    restart(2);
    ctl_gen = 1'b0;
    push_frame(0, 5);
    uf_seen = 0;
    repeat (90) step();
    chk("stall_one_underflow", uf_seen, 1);
    chk("stall_unlocked", locked, 1'b0);
    ctl_gen = 1'b1;
    wait_locked_de("stall_relock");

    // FIFO fill with idle timing: backpressure at full, then drain without loss
    restart(1);
    ctl_vtg_run = 1'b0;
    repeat (45) step();
    chk("full_tready_low", s_axis_video_tready, 1'b0);
    ctl_vtg_run = 1'b1; uf_seen = 0;
    repeat (250) step();
    chk("full_no_underflow", uf_seen, 0);

    // One-cycle reset pulse mid-frame
    wait_locked_de("midrst_pre_locked");
    ctl_rstn = 1'b0;
    step();
    ctl_rstn = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_data", vid_data, '0);
    chk("midrst_timing", {vid_de, vid_hsync, vid_vsync, vid_hblank, vid_vblank}, '0);
    chk("midrst_underflow", underflow, 1'b0);
    chk("midrst_tready", s_axis_video_tready, 1'b0);
    repeat (100) step();

    // Clock enable low for 3 cycles while locked
    wait_locked_de("clken_pre_locked");
    ctl_clken_pct = 0;
    repeat (3) step();
    ctl_clken_pct = 100;
    repeat (40) step();

    // Three forced underflows from single-pixel frames
    restart(2);
    ctl_gen = 1'b0; uf_seen = 0;
    for (int k = 0; k < 3; k++) begin
      push_frame(0, 1);
      repeat (90) step();
    end
    chk("forced_uf_pulses", uf_seen, 3);
`ifdef VID_OUT_UNDERFLOW_CNT_EN
    chk("forced_uf_cnt", underflow_cnt, 3);
`endif

    // Randomized traffic: junk, truncated frames, stalls, clock enable, enable and reset
    ctl_gen = 1'b1; ctl_junk_pct = 20; ctl_drop_pct = 10;
    ctl_valid_pct = 75; ctl_clken_pct = 85; en_off = 0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(999);
      ctl_rstn = (r >= 3);
      if (r >= 3 && r < 8 && en_off == 0) en_off = $urandom_range(1, 6);
      ctl_en = (en_off == 0);
      if (en_off != 0) en_off--;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
